// File: rtl/digital_temp_monitor_pkg.sv
// Shared definitions for the digital temperature monitor tile.
//   - default frame timing parameters
//   - reader FSM state encoding
//   - bit positions inside the uio_* buses and the fixed output-enable pattern
package digital_temp_monitor_pkg;

   localparam int unsigned IDLE_CYCLES_DEF = 4;
   localparam int unsigned NBITS_DEF       = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SETUP = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam int unsigned UIO_CS    = 0;
   localparam int unsigned UIO_SCK   = 1;
   localparam int unsigned UIO_SIO   = 2;
   localparam int unsigned UIO_ALARM = 3;
   localparam int unsigned UIO_VALID = 4;

   // CS, SCK, alarm and valid are outputs; SIO and bits 7..5 are inputs.
   localparam logic [7:0] UIO_OE = 8'b0001_1011;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/digital_temp_monitor_top_lm70_spi_reader.sv
// lm70_spi_reader: SPI master that polls an LM70-family sensor.
// Ports:
//   clk_i      - system clock, rising edge
//   rst_ni     - synchronous active-low reset
//   start_en_i - a new frame may start only while high
//   sio_i      - serial data from the sensor
//   cs_o       - registered chip select, active low
//   sck_o      - registered serial clock, idles low
//   data_o     - last 8 bits shifted in, MSB first
//   done_o     - high for the single cycle in which the frame has completed
module lm70_spi_reader
   import digital_temp_monitor_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
   parameter int unsigned NBITS       = NBITS_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_en_i,
   input  logic       sio_i,
   output logic       cs_o,
   output logic       sck_o,
   output logic [7:0] data_o,
   output logic       done_o
);

   localparam int unsigned SHIFT_CYCLES = 2 * NBITS;
   localparam int unsigned CNT_MAX      = max_u(IDLE_CYCLES, SHIFT_CYCLES);
   localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             cs_q,    cs_d;
   logic             sck_q,   sck_d;
   logic [7:0]       sr_q,    sr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cs_d    = cs_q;
      sck_d   = 1'b0;
      sr_d    = sr_q;

      case (state_q)
         ST_IDLE: begin
            cs_d = 1'b1;
            // Counter saturates at IDLE_LAST so a late ena starts a frame at once.
            if (cnt_q != IDLE_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (start_en_i) begin
               state_d = ST_SETUP;
               cnt_d   = '0;
               cs_d    = 1'b0;
            end
         end
         ST_SETUP: begin
            // First SCK high phase begins on the edge leaving SETUP.
            cs_d    = 1'b0;
            sck_d   = 1'b1;
            state_d = ST_SHIFT;
            cnt_d   = '0;
         end
         ST_SHIFT: begin
            cs_d = 1'b0;
            if (cnt_q == SHIFT_LAST) begin
               state_d = ST_DONE;
               cs_d    = 1'b1;
               cnt_d   = '0;
            end else begin
               sck_d = ~sck_q;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            cs_d    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            cs_d    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Sample on the edge where registered SCK rises; sensor data is stable then.
      if (sck_d && !sck_q) begin
         sr_d = {sr_q[6:0], sio_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         sr_q    <= sr_d;
      end
   end

   assign cs_o   = cs_q;
   assign sck_o  = sck_q;
   assign data_o = sr_q;
   assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/digital_temp_monitor_top.sv
// digital_temp_monitor_top: polls an LM70 sensor, latches the temperature
// byte (two's complement, 2 degC/LSB) and flags over-temperature.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   ena        - allows new frames to start
//   ui_in      - signed alarm threshold
//   uio_in     - bit 2 is SIO from the sensor
//   uo_out     - latched temperature byte
//   uio_out    - [0]=CS [1]=SCK [3]=alarm [4]=valid, others 0
//   uio_oe     - fixed direction pattern 8'h1B
module digital_temp_monitor_top
   import digital_temp_monitor_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
   parameter int unsigned NBITS       = NBITS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic       cs, sck, done;
   logic [7:0] data;

   logic [7:0] uo_q,    uo_d;
   logic       alarm_q, alarm_d;
   logic       valid_q, valid_d;

   logic       unused_uio;
   assign unused_uio = ^{uio_in[7:3], uio_in[1:0]};

   lm70_spi_reader #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .NBITS       (NBITS)
   ) u_reader (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_en_i (ena),
      .sio_i      (uio_in[UIO_SIO]),
      .cs_o       (cs),
      .sck_o      (sck),
      .data_o     (data),
      .done_o     (done)
   );

   always_comb begin
      uo_d    = uo_q;
      alarm_d = alarm_q;
      valid_d = valid_q;
      if (done) begin
         uo_d    = data;
         valid_d = 1'b1;
         // Compare the fresh reading, so threshold changes apply from the next frame.
         alarm_d = $signed(data) > $signed(ui_in);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uo_q    <= '0;
         alarm_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         uo_q    <= uo_d;
         alarm_q <= alarm_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      uio_out            = '0;
      uio_out[UIO_CS]    = cs;
      uio_out[UIO_SCK]   = sck;
      uio_out[UIO_ALARM] = alarm_q;
      uio_out[UIO_VALID] = valid_q;
   end

   assign uo_out = uo_q;
   assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_digital_temp_monitor_top.sv
module tb_digital_temp_monitor_top;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;

   logic        cs, sck, sio;
   logic [15:0] sensor_word = 16'h0000;
   logic [15:0] sens_sh = 16'h0000;

   int checks = 0;
   int failures = 0;
   int sck_pulses = 0;
   int cs_low_cnt = 0;
   int oe_bad = 0;
   int fixed_bad = 0;

   always #5 clk = ~clk;

   assign cs     = uio_out[0];
   assign sck    = uio_out[1];
   assign sio    = sens_sh[15];
   assign uio_in = {5'b0, sio, 2'b0};

   digital_temp_monitor_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // LM70 model: MSB appears when CS falls, advances on SCK falling edges.
   always @(negedge cs) sens_sh = sensor_word;
   always @(negedge sck) if (cs == 1'b0) sens_sh = {sens_sh[14:0], 1'b0};

   always @(posedge sck) sck_pulses++;

   always @(negedge clk) begin
      if (uio_oe !== 8'h1B) oe_bad++;
      if (uio_out[2] !== 1'b0 || uio_out[7:5] !== 3'b000) fixed_bad++;
      if (cs === 1'b0) cs_low_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_rst_cs"},    32'(cs),         32'h1);
      chk({tag, "_rst_sck"},   32'(sck),        32'h0);
      chk({tag, "_rst_uo"},    32'(uo_out),     32'h0);
      chk({tag, "_rst_valid"}, 32'(uio_out[4]), 32'h0);
      chk({tag, "_rst_alarm"}, 32'(uio_out[3]), 32'h0);
      chk({tag, "_rst_oe"},    32'(uio_oe),     32'h1B);
      @(negedge clk);
      rst_n = 1'b1;
      sck_pulses = 0;
      cs_low_cnt = 0;
   endtask

   typedef struct {
      logic [15:0] word;
      logic [7:0]  thr;
      logic [7:0]  exp_uo;
      logic        exp_alarm;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int bad;

      vecs[0] = '{16'h0C00, 8'h20, 8'h0C, 1'b0};
      vecs[1] = '{16'h0C00, 8'h0A, 8'h0C, 1'b1};
      vecs[2] = '{16'hFF00, 8'h00, 8'hFF, 1'b0};
      vecs[3] = '{16'hFF00, 8'hFE, 8'hFF, 1'b1};
      vecs[4] = '{16'h8100, 8'h80, 8'h81, 1'b1};
      vecs[5] = '{16'hAA00, 8'h7F, 8'hAA, 1'b0};
      vecs[6] = '{16'h0000, 8'hFF, 8'h00, 1'b1};
      vecs[7] = '{16'h7F00, 8'h7F, 8'h7F, 1'b0};

      for (int i = 0; i < 8; i++) begin
         sensor_word = vecs[i].word;
         ui_in       = vecs[i].thr;
         do_reset($sformatf("v%0d", i));
         step(21);
         chk($sformatf("v%0d_e21_valid", i), 32'(uio_out[4]), 32'h0);
         chk($sformatf("v%0d_e21_uo", i),    32'(uo_out),     32'h0);
         step(1);
         chk($sformatf("v%0d_uo", i),     32'(uo_out),     32'(vecs[i].exp_uo));
         chk($sformatf("v%0d_valid", i),  32'(uio_out[4]), 32'h1);
         chk($sformatf("v%0d_alarm", i),  32'(uio_out[3]), 32'(vecs[i].exp_alarm));
         chk($sformatf("v%0d_pulses", i), 32'(sck_pulses), 32'd8);
         chk($sformatf("v%0d_cslow", i),  32'(cs_low_cnt), 32'd17);
      end

      // Threshold change takes effect only at the next frame's DONE (edge 44).
      sensor_word = 16'h0C00;
      ui_in       = 8'h0A;
      do_reset("thr");
      step(22);
      chk("thr_alarm_first", 32'(uio_out[3]), 32'h1);
      @(negedge clk);
      ui_in = 8'h0C;
      step(21);
      chk("thr_alarm_held", 32'(uio_out[3]), 32'h1);
      chk("thr_uo_held",    32'(uo_out),     32'h0C);
      step(1);
      chk("thr_alarm_new",  32'(uio_out[3]), 32'h0);

      // Reset during the 4th SCK pulse of the second frame (edge 33).
      ui_in = 8'h20;
      do_reset("mid");
      step(22);
      chk("mid_uo_first", 32'(uo_out), 32'h0C);
      step(11);
      chk("mid_pre_sck", 32'(sck), 32'h1);
      chk("mid_pre_cs",  32'(cs),  32'h0);
      sensor_word = 16'h8100;
      do_reset("midrst");
      step(21);
      chk("mid_e21_valid", 32'(uio_out[4]), 32'h0);
      step(1);
      chk("mid_uo",     32'(uo_out),     32'h81);
      chk("mid_valid",  32'(uio_out[4]), 32'h1);
      chk("mid_pulses", 32'(sck_pulses), 32'd8);

      // ena low from reset: bus stays idle; raising ena starts a frame next edge.
      ena         = 1'b0;
      sensor_word = 16'h3C00;
      ui_in       = 8'h3B;
      do_reset("ena");
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         step(1);
         if (cs !== 1'b1 || sck !== 1'b0) bad++;
      end
      chk("ena_idle_bus",   32'(bad),        32'd0);
      chk("ena_no_pulses",  32'(sck_pulses), 32'd0);
      chk("ena_idle_valid", 32'(uio_out[4]), 32'h0);
      @(negedge clk);
      ena = 1'b1;
      step(18);
      chk("ena_e17_valid", 32'(uio_out[4]), 32'h0);
      step(1);
      chk("ena_uo",    32'(uo_out),     32'h3C);
      chk("ena_valid", 32'(uio_out[4]), 32'h1);
      chk("ena_alarm", 32'(uio_out[3]), 32'h1);

      chk("oe_constant", 32'(oe_bad),    32'd0);
      chk("uio_fixed",   32'(fixed_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/digital_temp_monitor_top.md
Name: digital_temp_monitor_top

Overview:
Top-level tile of a digital temperature monitor. Acts as SPI master to an LM70-family sensor and reads the 8 MSBs of each 16-bit frame, which is two's-complement with 2 °C per LSB. It continuously re-polls the sensor and presents the last reading on uo_out. It raises an over-temperature alarm against an 8-bit threshold supplied on ui_in.

Parameters:
IDLE_CYCLES, 4, clk cycles with CS high between frames (also after reset).
NBITS, 8, number of MSBs clocked in per frame.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
ena  in  1  design enable; new frames start only while ena=1.
ui_in  in  8  alarm threshold, signed, same encoding as the reading.
uio_in  in  8  bit 2 = SIO (serial data from sensor); other bits ignored.
uo_out  out  8  latched temperature byte.
uio_out  out  8  [0]=CS (active-low chip select), [1]=SCK, [2]=0, [3]=alarm, [4]=valid, [7:5]=0.
uio_oe  out  8  constant 8'b0001_1011 (bit 2 input; 5..7 unused inputs).

Behaviour:
- Reset is synchronous and active-low. On a clk edge with rst_n=0: state IDLE, CS=1, SCK=0, counters=0, shift reg=0, uo_out=0, alarm=0, valid=0.
- CS, SCK and the other uio_out bits are driven straight from registers, with no combinational path from inputs.
- SCK idles low. The sensor presents the MSB on SIO as soon as CS falls, and advances SIO on each SCK falling edge.
- FSM:
  - IDLE: CS=1, SCK=0. Count IDLE_CYCLES; when the count is done and ena=1, go to SETUP.
  - SETUP: CS=0 for 1 cycle, SCK=0.
  - SHIFT: 2*NBITS cycles. SCK toggles every clk (0->1->0...). On each edge where the SCK register goes 0->1, shift SIO (uio_in[2]) into the LSB of the shift reg; MSB-first, so the first bit becomes bit 7. After the NBITS-th high phase, SCK returns to 0 and the state moves to DONE.
  - DONE: CS=1, SCK=0. Load uo_out from the shift reg, set valid=1 (sticky until reset), update alarm, then go to IDLE.
- Frame length: 1 SETUP + 16 SHIFT + 1 DONE = 18 cycles. First uo_out update occurs IDLE_CYCLES+18 edges after reset release, i.e. edge 22 with defaults. Exactly NBITS SCK rising edges occur per frame.
- Alarm = signed(uo_out_next) > signed(ui_in). It is updated only in DONE and held otherwise, so ui_in changes take effect at the next frame.
- If ena drops mid-frame, the frame completes; the FSM then waits in IDLE.
- Reset asserted mid-frame: CS=1 and SCK=0 on that same edge. The partial data is discarded and uo_out clears to 0.
- There is no bus-error detection; the value read is latched as is (0xFF = -2 °C; all-zero reads are valid).

Decomposition:
- Shared package: FSM state enum (IDLE, SETUP, SHIFT, DONE), default IDLE_CYCLES/NBITS, uio bit-index constants (CS=0, SCK=1, SIO=2, ALARM=3, VALID=4), UIO_OE constant.
- One sub-module, lm70_spi_reader. It contains the FSM, SCK/CS generation and the shift register, and outputs data[7:0] plus a done pulse. The top holds the output registers, the alarm compare and the uio mapping.

Test Plan:
- Sensor preloaded 16'h0C00, ui_in=8'h20 -> after reset, first DONE at edge 22; uo_out=8'h0C, valid=1, alarm=0. CS low for 17 cycles; exactly 8 SCK pulses.
- Sensor 16'h0C00, ui_in=8'h0A -> alarm=1 after first frame. Change ui_in to 8'h0C -> alarm=0 after the next frame, not earlier.
- Sensor 16'hFF00, ui_in=8'h00 -> uo_out=8'hFF; signed compare gives alarm=0. With ui_in=8'hFE -> alarm=1.
- Sensor 16'h8100 -> uo_out=8'h81 (MSB-first ordering check). Alternating 16'hAA00 -> 8'hAA.
- rst_n low during the 4th SCK pulse -> CS=1 and SCK=0 on that edge; uo_out=0, valid=0. After release, a fresh frame starts after IDLE_CYCLES and reads correctly.
- ena=0 from reset -> CS stays 1 and SCK stays 0 indefinitely. uio_oe=8'h1B at all times, including during reset.
